xs3_serial_adder: RTL and testbench

//  Multi-digit decimal adder using Excess-3 arithmetic, one digit per clock (LSD first).

---
 rtl/xs3_serial_adder_pkg.sv | 11 +
 rtl/xs3_serial_adder_if.sv | 16 +
 rtl/xs3_serial_adder_digit.sv | 15 +
 rtl/xs3_serial_adder.sv | 106 ++++++++++
 tb/tb_xs3_serial_adder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/xs3_serial_adder_pkg.sv
// xs3_pkg: shared Excess-3 constants, FSM state type and digit legality helpers.
package xs3_pkg;
  localparam logic [3:0] XS3_BIAS = 4'd3;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic is_bcd_digit(input logic [3:0] d);
    return d <= 4'd9;
  endfunction
  function automatic logic is_xs3_digit(input logic [3:0] d);
    return d >= 4'd3 && d <= 4'd12;
  endfunction
endpackage

// File: rtl/xs3_serial_adder_if.sv
// xs3_serial_adder_if: start/ready/done handshake plus operand and result buses.
interface xs3_serial_adder_if #(parameter int DIGITS = 4);
  localparam int W = 4 * DIGITS;
  logic         start;
  logic         mode;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;
  modport master(output start, mode, cin, a, b, input ready, done, sum, cout, err);
  modport slave(input start, mode, cin, a, b, output ready, done, sum, cout, err);
endinterface

// File: rtl/xs3_serial_adder_digit.sv
// xs3_digit_adder: one Excess-3 digit addition with decimal carry.
module xs3_digit_adder
  import xs3_pkg::*;
(
  input  logic [3:0] ax_i,
  input  logic [3:0] bx_i,
  input  logic       cin_i,
  output logic [3:0] r_o,
  output logic       cout_o
);
  logic [4:0] s;
  assign s      = {1'b0, ax_i} + {1'b0, bx_i} + {4'b0, cin_i};
  assign cout_o = s[4];
  assign r_o    = s[4] ? s[3:0] + XS3_BIAS : s[3:0] - XS3_BIAS;
endmodule

// File: rtl/xs3_serial_adder.sv
// xs3_serial_adder: multi-digit BCD/Excess-3 adder, one digit per clock, LSD first.
module xs3_serial_adder
  import xs3_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst_n,
  xs3_serial_adder_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          mode_q, mode_d, c_q, c_d, cout_q, cout_d, err_q, err_d;
  logic          ready_q, ready_d, done_q, done_d;
  logic [3:0]    ax, bx, r;
  logic          c_nx, bad_digit;
  // Operands shift right so the current digit always sits in the low nibble.
  assign ax = mode_q ? a_q[3:0] : a_q[3:0] + XS3_BIAS;
  assign bx = mode_q ? b_q[3:0] : b_q[3:0] + XS3_BIAS;
  assign bad_digit = mode_q ? !(is_xs3_digit(a_q[3:0]) && is_xs3_digit(b_q[3:0]))
                            : !(is_bcd_digit(a_q[3:0]) && is_bcd_digit(b_q[3:0]));
  xs3_digit_adder u_digit (
    .ax_i  (ax),
    .bx_i  (bx),
    .cin_i (c_q),
    .r_o   (r),
    .cout_o(c_nx)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    mode_d  = mode_q;
    c_d     = c_q;
    cout_d  = cout_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d     = bus.a;
        b_d     = bus.b;
        mode_d  = bus.mode;
        c_d     = bus.cin;
        idx_d   = '0;
        err_d   = 1'b0;
        cout_d  = 1'b0;
        sum_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_d = a_q >> 4;
        b_d = b_q >> 4;
        c_d = c_nx;
        sum_d[idx_q*4 +: 4] = mode_q ? r : r - XS3_BIAS;
        err_d = err_q | bad_digit;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST) begin
          idx_d   = '0;
          cout_d  = c_nx;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
    done_d  = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      mode_q  <= 1'b0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      mode_q  <= mode_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end
  assign bus.ready = ready_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.err   = err_q;
endmodule

// File: tb/tb_xs3_serial_adder.sv
// tb_xs3_serial_adder: directed and random checks of 1-, 4- and 8-digit adders against a decimal model.
module tb_xs3_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, mode, cin;
  logic [31:0] a, b;
  int          sel;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;

  xs3_serial_adder_if #(.DIGITS(1)) if1 ();
  xs3_serial_adder_if #(.DIGITS(4)) if4 ();
  xs3_serial_adder_if #(.DIGITS(8)) if8 ();
  xs3_serial_adder #(.DIGITS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  xs3_serial_adder #(.DIGITS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  xs3_serial_adder #(.DIGITS(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  assign if1.start = start && sel == 1;
  assign if4.start = start && sel == 4;
  assign if8.start = start && sel == 8;
  assign if1.mode = mode;
  assign if4.mode = mode;
  assign if8.mode = mode;
  assign if1.cin = cin;
  assign if4.cin = cin;
  assign if8.cin = cin;
  assign if1.a = a[3:0];
  assign if1.b = b[3:0];
  assign if4.a = a[15:0];
  assign if4.b = b[15:0];
  assign if8.a = a;
  assign if8.b = b;

  logic [31:0] sum_s;
  logic        ready_s, done_s, cout_s, err_s;
  assign sum_s   = sel == 1 ? {28'b0, if1.sum} : sel == 4 ? {16'b0, if4.sum} : if8.sum;
  assign ready_s = sel == 1 ? if1.ready : sel == 4 ? if4.ready : if8.ready;
  assign done_s  = sel == 1 ? if1.done : sel == 4 ? if4.done : if8.done;
  assign cout_s  = sel == 1 ? if1.cout : sel == 4 ? if4.cout : if8.cout;
  assign err_s   = sel == 1 ? if1.err : sel == 4 ? if4.err : if8.err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Decimal reference: decode digits to integers, add, re-encode.
  task automatic ref_model(input int n, input logic m, input logic [31:0] av, input logic [31:0] bv,
                           input logic ci, output logic [31:0] s, output logic co, output logic e);
    longint x = 0, y = 0, p = 1, tot;
    logic [31:0] aw = av, bw = bv;
    e = 1'b0;
    for (int i = 0; i < n; i++) begin
      int da = int'(aw[4*i +: 4]) - (m ? 3 : 0);
      int db = int'(bw[4*i +: 4]) - (m ? 3 : 0);
      if (da < 0 || da > 9 || db < 0 || db > 9) e = 1'b1;
      x += da * p;
      y += db * p;
      p *= 10;
    end
    tot = x + y + longint'(ci);
    co = tot >= p;
    tot = tot % p;
    s = '0;
    for (int i = 0; i < n; i++) begin
      s[4*i +: 4] = 4'(tot % 10 + (m ? 3 : 0));
      tot = tot / 10;
    end
  endtask

  function automatic logic [31:0] rnd_ops(input int n, input logic m);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[4*i +: 4] = 4'($urandom_range(0, 9) + (m ? 3 : 0));
    return v;
  endfunction

  task automatic do_op(input int n, input logic m, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input bit glitch, input string tag);
    logic [31:0] es;
    logic ec, ee;
    int cnt = 0;
    ref_model(n, m, av, bv, ci, es, ec, ee);
    @(negedge clk);
    sel = n; mode = m; a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!done_s && cnt < 40) begin
      @(posedge clk);
      #1 cnt++;
      if (glitch && cnt == 1) begin
        start = 1'b1; a = ~av; b = ~bv; mode = ~m; cin = ~ci;
      end
      if (cnt == 2) start = 1'b0;
    end
    check({tag, "_lat"}, cnt, n);
    check({tag, "_err"}, {31'b0, err_s}, {31'b0, ee});
    if (!ee) begin
      check({tag, "_sum"}, sum_s, es);
      check({tag, "_cout"}, {31'b0, cout_s}, {31'b0, ec});
    end
    @(posedge clk);
    #1 check({tag, "_done1"}, {31'b0, done_s}, 32'd0);
    check({tag, "_rdy"}, {31'b0, ready_s}, 32'd1);
  endtask

  initial begin
    bit seen;
    logic m;
    logic [31:0] x, y;
    sel = 4; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
    rst_n = 1'b0;
    #12;
    check("rst_ready", {31'b0, ready_s}, 32'd1);
    check("rst_done", {31'b0, done_s}, 32'd0);
    check("rst_sum", sum_s, 32'd0);
    check("rst_cout_err", {30'b0, cout_s, err_s}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    do_op(4, 1'b0, 32'h1234, 32'h5678, 1'b0, 1'b0, "bcd");
    check("bcd_const", {sum_s[15:0], 15'b0, cout_s}, {16'h6912, 16'h0});
    do_op(4, 1'b0, 32'h9999, 32'h0001, 1'b0, 1'b0, "wrap");
    check("wrap_const", {sum_s[15:0], 15'b0, cout_s}, {16'h0000, 16'h1});
    do_op(4, 1'b0, 32'h0999, 32'h0000, 1'b1, 1'b0, "cin");
    check("cin_const", {sum_s[15:0], 15'b0, cout_s}, {16'h1000, 16'h0});
    do_op(4, 1'b1, 32'h4567, 32'h89AB, 1'b0, 1'b0, "xs3");
    check("xs3_const", {sum_s[15:0], 15'b0, cout_s}, {16'h9C45, 16'h0});
    do_op(4, 1'b0, 32'h12A4, 32'h0001, 1'b0, 1'b0, "illegal");
    check("illegal_err", {31'b0, err_s}, 32'd1);
    do_op(4, 1'b0, 32'h0042, 32'h0058, 1'b0, 1'b0, "clear");
    check("clear_const", {sum_s[15:0], 14'b0, cout_s, err_s}, {16'h0100, 16'h0});
    do_op(4, 1'b0, 32'h2468, 32'h1357, 1'b1, 1'b1, "glitch");
    check("glitch_const", {sum_s[15:0], 15'b0, cout_s}, {16'h3826, 16'h0});

    // Abort mid-RUN after two digits have been written.
    @(negedge clk);
    sel = 4; mode = 1'b0; a = 32'h1234; b = 32'h5678; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 check("abort_partial", sum_s, 32'h0012);
    rst_n = 1'b0;
    #1 check("abort_ready", {31'b0, ready_s}, 32'd1);
    check("abort_sum", sum_s, 32'd0);
    check("abort_cout_err", {30'b0, cout_s, err_s}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 seen |= done_s;
    end
    check("abort_nodone", {31'b0, seen}, 32'd0);

    for (int i = 0; i < 60; i++) begin
      int n = i % 3 == 0 ? 1 : i % 3 == 1 ? 8 : 4;
      m = 1'($urandom_range(0, 1));
      x = rnd_ops(n, m);
      y = rnd_ops(n, m);
      if ($urandom_range(0, 7) == 0) x[4*$urandom_range(0, n - 1) +: 4] = 4'($urandom);
      do_op(n, m, x, y, 1'($urandom_range(0, 1)), 1'b0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
